// File: rtl/multiword_add_seq.sv
// Multi-word add/sub sequencer.
// Splits a WORDS*16-bit add or subtract into WORDS passes through an external
// combinational 16-bit adder. The least significant word goes first, and each
// word's carry-out is fed back as the next word's carry-in. The assembled sum,
// the final carry and the signed overflow flag are returned on a valid/ready
// handshake.
module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in_a,
    input  logic [16*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    input  logic                  in_sub,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_s,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      word_a;
    logic [15:0]      word_b;
    logic             last_word;

    assign last_word = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> run WORDS cycles -> hold result until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_word) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshakes and adder drive (adder inputs are quiet outside RUN)
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state_q == RUN) begin
            add_a   = word_a;
            add_b   = word_b;
            add_cin = carry_q;
        end
    end

    // Select the current operand word from the latched operands
    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                word_a = a_q[16*w +: 16];
                word_b = b_q[16*w +: 16];
            end
        end
    end

    // Datapath next-state: latch operands on accept, collect sum words while running
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = in_a;
            b_d     = in_sub ? ~in_b : in_b;
            carry_d = in_sub ? 1'b1 : in_cin;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_q == IDX_W'(w)) begin
                    sum_d[16*w +: 16] = add_s;
                end
            end
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (last_word) begin
                // b_q is already inverted for subtract, so its MSB is the effective sign
                cout_d = add_cout;
                ovf_d  = (a_q[W-1] == b_q[W-1]) & (add_s[15] != a_q[W-1]);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule
